seven_seg_scan_ctrl: RTL and testbench

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
//   Converts a 16-bit binary value to five BCD digits with a sequential
//   double-dabble (one step per clock, 16 steps) and time-multiplexes the
//   digits onto a 5-digit common-anode 7-segment display, with
//   leading-zero blanking.
//
// Ports
//   clk   in   sole clock, rising edge
//   rst   in   asynchronous active-high reset
//   numb  in   [15:0] binary value to display
//   load  in   start a conversion of numb (ignored while busy)
//   busy  out  high while converting
//   done  out  one-cycle pulse after the new digits are latched
//   an    out  [4:0] digit enables, active-low (bit0 = ones)
//   seg   out  [6:0] {g,f,e,d,c,b,a}, active-low
module seven_seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] numb,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [4:0]  an,
    output logic [6:0]  seg
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic {IDLE = 1'b0, CONVERT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [15:0]      bin_q;
    logic [19:0]      bcd_q;
    logic [3:0]       step_q;
    logic [19:0]      digits_q;
    logic             done_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       idx_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = CONVERT;
            CONVERT: if (step_q == 4'd15) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CONVERT);
        done = done_q;
    end

    // ---------------- double-dabble datapath ----------------
    logic [19:0] bcd_adj;
    logic [35:0] dd_shift;

    for (genvar n = 0; n < 5; n++) begin : g_adj
        assign bcd_adj[n*4 +: 4] = (bcd_q[n*4 +: 4] >= 4'd5) ? bcd_q[n*4 +: 4] + 4'd3
                                                               : bcd_q[n*4 +: 4];
    end

    // The BCD MSB shifted out is always 0 for a 16-bit input (max 65535).
    assign dd_shift = {bcd_adj, bin_q} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            step_q   <= '0;
            digits_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (load) begin
                    bin_q  <= numb;
                    bcd_q  <= '0;
                    step_q <= '0;
                end
            end else begin
                bcd_q  <= dd_shift[35:16];
                bin_q  <= dd_shift[15:0];
                step_q <= step_q + 4'd1;
                // 16th step: publish the post-step BCD value directly
                if (step_q == 4'd15) begin
                    digits_q <= dd_shift[35:16];
                    done_q   <= 1'b1;
                end
            end
        end
    end

    // ---------------- scan divider / digit index ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            idx_q <= (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // ---------------- display decode (registered state only) ----------------
    logic [3:0] cur_digit;
    logic       blank;

    always_comb begin
        cur_digit = 4'd0;
        blank     = 1'b0;
        case (idx_q)
            3'd0: cur_digit = digits_q[3:0];
            3'd1: begin cur_digit = digits_q[7:4];   blank = (digits_q[19:4]  == '0); end
            3'd2: begin cur_digit = digits_q[11:8];  blank = (digits_q[19:8]  == '0); end
            3'd3: begin cur_digit = digits_q[15:12]; blank = (digits_q[19:12] == '0); end
            3'd4: begin cur_digit = digits_q[19:16]; blank = (digits_q[19:16] == '0); end
            default: blank = 1'b1;
        endcase
    end

    always_comb begin
        an = blank ? 5'b11111 : ~(5'b00001 << idx_q);
        if (blank) seg = 7'b1111111;
        else begin
            case (cur_digit)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = 7'b1111111;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] numb;
    logic        load;
    logic        busy, done;
    logic [4:0]  an;
    logic [6:0]  seg;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(.SCAN_DIV(D)) dut (
        .clk(clk), .rst(rst), .numb(numb), .load(load),
        .busy(busy), .done(done), .an(an), .seg(seg)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int dn_cnt = 0;
    int bz_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int pow10(input int e);
        int p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    // Behavioural model: a conversion is "16 cycles of busy, then the value
    // appears"; the scan slot is just elapsed cycles / D mod 5.
    int m_rem, m_pend, m_val, m_tick;
    bit m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem  <= 0;
            m_val  <= 0;
            m_done <= 1'b0;
            m_tick <= 0;
        end else begin
            m_tick <= m_tick + 1;
            if (m_rem != 0) begin
                m_rem  <= m_rem - 1;
                m_done <= (m_rem == 1);
                if (m_rem == 1) m_val <= m_pend;
            end else begin
                m_done <= 1'b0;
                if (load) begin
                    m_pend <= int'(numb);
                    m_rem  <= 16;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always begin
        @(negedge clk);
        if (chk_en) begin
            int slot, dig;
            bit blk;
            logic [4:0] ea;
            logic [6:0] es;
            slot = (m_tick / D) % 5;
            dig  = (m_val / pow10(slot)) % 10;
            blk  = (slot >= 1) && (m_val < pow10(slot));
            ea   = blk ? 5'b11111 : ~(5'b00001 << slot);
            es   = blk ? 7'b1111111 : seg_of(dig);
            chk("busy", busy, 32'(m_rem != 0));
            chk("done", done, 32'(m_done));
            chk("an", an, ea);
            chk("seg", seg, es);
        end
        if (done === 1'b1) dn_cnt++;
        if (busy === 1'b1) bz_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input int v);
        numb = 16'(v);
        load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
        if (done !== 1'b1) chk("done_timeout", 0, 1);
    endtask

    logic [6:0] cap_seg [5];
    int cap_blank, cap_bad;

    // Watch one full scan rotation (5*D cycles) and record what each slot shows.
    task automatic capture();
        for (int i = 0; i < 5; i++) cap_seg[i] = 7'bx;
        cap_blank = 0;
        cap_bad   = 0;
        repeat (5 * D) begin
            @(negedge clk);
            if (an == 5'b11111) begin
                cap_blank++;
                if (seg != 7'b1111111) cap_bad++;
            end else begin
                for (int i = 0; i < 5; i++)
                    if (an == ~(5'b00001 << i)) cap_seg[i] = seg;
            end
        end
        tick(1);
    endtask

    initial begin
        int n;
        rst  = 1'b1;
        load = 1'b0;
        numb = 16'd0;
        #1 chk_en = 1'b1;
        tick(3);
        chk("rst_an", an, 5'b11110);
        chk("rst_seg", seg, 7'b1000000);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        // Maximum value, load on the very first edge after reset.
        dn_cnt = 0; bz_cnt = 0;
        pulse_load(65535);
        wait_done(n);
        chk("max_done_lat", n, 16);
        tick(1);
        chk("max_done_width", done, 0);
        tick(3);
        chk("max_done_cnt", dn_cnt, 1);
        chk("max_busy_cycles", bz_cnt, 16);
        capture();
        chk("max_s0", cap_seg[0], 7'b0010010);
        chk("max_s1", cap_seg[1], 7'b0110000);
        chk("max_s2", cap_seg[2], 7'b0010010);
        chk("max_s3", cap_seg[3], 7'b0010010);
        chk("max_s4", cap_seg[4], 7'b0000010);

        // Blanking.
        pulse_load(7);
        wait_done(n);
        tick(2);
        capture();
        chk("seven_s0", cap_seg[0], 7'b1111000);
        chk("seven_blank", cap_blank, 4 * D);
        chk("seven_blankseg", cap_bad, 0);
        pulse_load(0);
        wait_done(n);
        tick(2);
        capture();
        chk("zero_s0", cap_seg[0], 7'b1000000);
        chk("zero_blank", cap_blank, 4 * D);

        // Embedded zeros.
        pulse_load(1005);
        wait_done(n);
        tick(2);
        capture();
        chk("e_s0", cap_seg[0], 7'b0010010);
        chk("e_s1", cap_seg[1], 7'b1000000);
        chk("e_s2", cap_seg[2], 7'b1000000);
        chk("e_s3", cap_seg[3], 7'b1111001);
        chk("e_blank", cap_blank, D);

        // Handshake: second load during busy is dropped.
        dn_cnt = 0;
        pulse_load(1234);
        tick(2);
        pulse_load(9999);
        tick(30);
        chk("hs_done_cnt", dn_cnt, 1);
        capture();
        chk("hs_s0", cap_seg[0], 7'b0011001);
        chk("hs_s1", cap_seg[1], 7'b0110000);
        chk("hs_s2", cap_seg[2], 7'b0100100);
        chk("hs_s3", cap_seg[3], 7'b1111001);

        // Continuous load: done pulses 17 cycles apart.
        numb = 16'd4242;
        load = 1'b1;
        wait_done(n);
        tick(1);
        wait_done(n);
        chk("b2b_spacing", n + 1, 17);
        load = 1'b0;
        tick(20);

        // Reset mid-conversion: abort, no done, digits cleared.
        dn_cnt = 0;
        pulse_load(4321);
        tick(5);
        #2 rst = 1'b1;
        #1;
        chk("arst_an", an, 5'b11110);
        chk("arst_seg", seg, 7'b1000000);
        chk("arst_busy", busy, 0);
        tick(2);
        rst = 1'b0;
        tick(25);
        chk("arst_done_cnt", dn_cnt, 0);
        capture();
        chk("arst_s0", cap_seg[0], 7'b1000000);
        chk("arst_blank", cap_blank, 4 * D);

        // Randomized traffic, checked by the model every cycle.
        repeat (1500) begin
            numb = 16'($urandom);
            load = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            tick(1);
        end
        load = 1'b0;
        tick(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
